// File: rtl/booth_r4_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_seq_multiplier
// Brief    : Iterative radix-4 Booth multiplier, one Booth digit per clock,
//            signed/unsigned per operation, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_seq_multiplier #(
  parameter int WIDTH = 16  // operand width; even and >= 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N     = WIDTH / 2 + 1;  // Booth digits per operation
  localparam int CNT_W = $clog2(N);
  localparam int PP_W  = WIDTH + 3;      // partial product width
  localparam int RC_W  = WIDTH + 3;      // recode register: B_ext plus appended 0
  localparam int ACC_W = 2 * WIDTH + 4;  // internal accumulator width

  localparam logic [CNT_W-1:0] C_LAST_DIGIT = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH:0]     a_ext_q, a_ext_d;
  logic [RC_W-1:0]    rc_q,    rc_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [2*WIDTH-1:0] prod_q,  prod_d;

  logic [PP_W-1:0]    pp_pos1;
  logic [PP_W-1:0]    pp_pos2;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   pp_weighted;
  logic [ACC_W-1:0]   acc_sum;

  // +A_ext and +2*A_ext, both sign-extended to the partial product width.
  assign pp_pos1 = {{2{a_ext_q[WIDTH]}}, a_ext_q};
  assign pp_pos2 = {a_ext_q[WIDTH], a_ext_q, 1'b0};

  // Recode the current Booth triplet into a signed partial product.
  always_comb begin
    pp = '0;
    case (rc_q[2:0])
      3'b001, 3'b010: pp = pp_pos1;
      3'b011:         pp = pp_pos2;
      3'b100:         pp = -pp_pos2;
      3'b101, 3'b110: pp = -pp_pos1;
      default:        pp = '0;
    endcase
  end

  // Digit i carries weight 4^i: sign-extend, then shift left by 2*i.
  assign pp_ext      = {{(ACC_W - PP_W){pp[PP_W-1]}}, pp};
  assign pp_weighted = pp_ext << {cnt_q, 1'b0};
  assign acc_sum     = acc_q + pp_weighted;

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_ext_d = a_ext_q;
    rc_d    = rc_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_CALC;
          a_ext_d = {signed_mode & a[WIDTH-1], a};
          rc_d    = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        rc_d  = {{2{rc_q[RC_W-1]}}, rc_q[RC_W-1:2]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_DIGIT) begin
          state_d = S_DONE;
          cnt_d   = '0;
          // product is held separately so it survives the next accept
          prod_d  = acc_sum[2*WIDTH-1:0];
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_ext_q <= '0;
      rc_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_ext_q <= a_ext_d;
      rc_q    <= rc_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign product   = prod_q;

endmodule
`default_nettype wire
